reg_write_arbiter: RTL and testbench

REG_WRITE_ARBITER -- requirements
Module: reg_write_arbiter

---
 rtl/reg_write_arbiter.sv | 141 ++++++++++++++
 tb/tb_reg_write_arbiter.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/reg_write_arbiter.sv
`default_nettype none
//==============================================================================
// Module   : reg_write_arbiter
// Purpose  : Clears a register bank after reset, then arbitrates register
//            writes from two requesters (ALU writeback and memory load)
//            using round-robin selection onto a single bank write port.
//            A write to address 0 completes the handshake but is suppressed
//            because x0 is hardwired to zero.
// Ports    : clock, reset                 - clock and synchronous active-high reset
//            req0_valid/addr/data/ready    - requester 0 (ALU writeback)
//            req1_valid/addr/data/ready    - requester 1 (memory load)
//            write, regwriteaddress, datain - registered bank write port
//            busy_clear                    - clear sequence in progress
//            conflict_cnt                  - saturating count of contended cycles
// Revision : 1.0 - initial release
//==============================================================================
module reg_write_arbiter #(
    parameter int NREGS  = 32,
    parameter int DATA_W = 64,
    parameter int ADDR_W = 5
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req0_valid,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_data,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_data,
    output logic              req1_ready,
    output logic              write,
    output logic [ADDR_W-1:0] regwriteaddress,
    output logic [DATA_W-1:0] datain,
    output logic              busy_clear,
    output logic [15:0]       conflict_cnt
);

    localparam logic [ADDR_W-1:0] c_last_addr = ADDR_W'(NREGS - 1);
    localparam logic [15:0]       c_cnt_max   = 16'hFFFF;

    typedef enum logic [0:0] {
        S_CLEAR = 1'b0,
        S_RUN   = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [ADDR_W-1:0]   r_clr_cnt;
    logic                r_ptr;        // 0: req0 has priority, 1: req1 has priority
    logic                r_write;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_data;
    logic [15:0]         r_conflict;
    logic                w_grant0;
    logic                w_grant1;

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_CLEAR;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and grant logic
    always_comb begin
        w_state_nxt = r_state;
        w_grant0    = 1'b0;
        w_grant1    = 1'b0;
        case (r_state)
            S_CLEAR: begin
                // Leave on the same edge that issues the last address so the
                // counter never wraps back to 0.
                if (r_clr_cnt == c_last_addr) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                w_grant0 = req0_valid & (~req1_valid | ~r_ptr);
                w_grant1 = req1_valid & (~req0_valid |  r_ptr);
            end
            default: begin
                w_state_nxt = S_CLEAR;
            end
        endcase
    end

    // Readies and busy are forced during reset so nothing can handshake
    // against a stale RUN state before the first reset edge lands.
    assign req0_ready = w_grant0 & ~reset;
    assign req1_ready = w_grant1 & ~reset;
    assign busy_clear = (r_state == S_CLEAR) | reset;

    // Clear sequencing, arbitration bookkeeping and the registered write port
    always_ff @(posedge clock) begin
        if (reset) begin
            r_clr_cnt  <= '0;
            r_ptr      <= 1'b0;
            r_write    <= 1'b0;
            r_addr     <= '0;
            r_data     <= '0;
            r_conflict <= '0;
        end else if (r_state == S_CLEAR) begin
            r_write <= 1'b1;
            r_addr  <= r_clr_cnt;
            r_data  <= '0;
            if (r_clr_cnt != c_last_addr) begin
                r_clr_cnt <= r_clr_cnt + 1'b1;
            end
        end else begin
            r_write <= 1'b0;
            if (w_grant0) begin
                r_ptr <= 1'b1;
                if (req0_addr != '0) begin
                    r_write <= 1'b1;
                    r_addr  <= req0_addr;
                    r_data  <= req0_data;
                end
            end else if (w_grant1) begin
                r_ptr <= 1'b0;
                if (req1_addr != '0) begin
                    r_write <= 1'b1;
                    r_addr  <= req1_addr;
                    r_data  <= req1_data;
                end
            end
            if (req0_valid && req1_valid && (r_conflict != c_cnt_max)) begin
                r_conflict <= r_conflict + 16'd1;
            end
        end
    end

    assign write           = r_write;
    assign regwriteaddress = r_addr;
    assign datain          = r_data;
    assign conflict_cnt    = r_conflict;

endmodule
`default_nettype wire

// File: tb/tb_reg_write_arbiter.sv
`default_nettype none
//==============================================================================
// Module   : tb_reg_write_arbiter
// Purpose  : Directed self-checking bench for reg_write_arbiter covering the
//            clear sequence, single and contended grants, x0 suppression,
//            reset during clear, and long-run round-robin with saturation.
// Revision : 1.0 - initial release
//==============================================================================
module tb_reg_write_arbiter;

    localparam int NREGS  = 32;
    localparam int DATA_W = 64;
    localparam int ADDR_W = 5;

    logic              clock;
    logic              reset;
    logic              req0_valid;
    logic [ADDR_W-1:0] req0_addr;
    logic [DATA_W-1:0] req0_data;
    logic              req0_ready;
    logic              req1_valid;
    logic [ADDR_W-1:0] req1_addr;
    logic [DATA_W-1:0] req1_data;
    logic              req1_ready;
    logic              write;
    logic [ADDR_W-1:0] regwriteaddress;
    logic [DATA_W-1:0] datain;
    logic              busy_clear;
    logic [15:0]       conflict_cnt;

    int checks = 0;
    int errors = 0;

    logic [DATA_W-1:0] bank [NREGS];

    reg_write_arbiter #(
        .NREGS  (NREGS),
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .req0_valid      (req0_valid),
        .req0_addr       (req0_addr),
        .req0_data       (req0_data),
        .req0_ready      (req0_ready),
        .req1_valid      (req1_valid),
        .req1_addr       (req1_addr),
        .req1_data       (req1_data),
        .req1_ready      (req1_ready),
        .write           (write),
        .regwriteaddress (regwriteaddress),
        .datain          (datain),
        .busy_clear      (busy_clear),
        .conflict_cnt    (conflict_cnt)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Register bank fed by the arbiter's write port
    always @(posedge clock) begin
        if (write) bank[regwriteaddress] <= datain;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        logic exp0;
        reset      = 1'b1;
        req0_valid = 1'b1;
        req0_addr  = 5'd7;
        req0_data  = 64'h77;
        req1_valid = 1'b0;
        req1_addr  = '0;
        req1_data  = '0;

        // Reset state
        tick();
        tick();
        chk("rst_write", write, 0);
        chk("rst_addr", regwriteaddress, 0);
        chk("rst_data", datain, 0);
        chk("rst_conflict", conflict_cnt, 0);
        chk("rst_busy", busy_clear, 1);
        chk("rst_ready0", req0_ready, 0);
        chk("rst_ready1", req1_ready, 0);

        // Clear sequence: 32 writes of zero, readies held low
        reset = 1'b0;
        for (int i = 0; i < NREGS; i++) begin
            tick();
            chk("clr_write", write, 1);
            chk("clr_addr", regwriteaddress, i);
            chk("clr_data", datain, 0);
            chk("clr_busy", busy_clear, (i < NREGS - 1) ? 1 : 0);
            if (i < NREGS - 1) chk("clr_ready0", req0_ready, 0);
            if (i == NREGS - 2) req0_valid = 1'b0;
        end
        tick();
        chk("run_idle_write", write, 0);
        chk("run_idle_busy", busy_clear, 0);

        // Single requester 0 transfer
        req0_valid = 1'b1;
        req0_addr  = 5'd5;
        req0_data  = 64'h1234;
        #1;
        chk("r0_ready", req0_ready, 1);
        chk("r0_ready1", req1_ready, 0);
        tick();
        req0_valid = 1'b0;
        chk("r0_write", write, 1);
        chk("r0_addr", regwriteaddress, 5);
        chk("r0_data", datain, 64'h1234);
        tick();
        chk("r0_write_off", write, 0);
        chk("r0_addr_hold", regwriteaddress, 5);
        chk("r0_data_hold", datain, 64'h1234);
        chk("r0_bank5", bank[5], 64'h1234);

        // Requester 1 write to x0 is accepted but suppressed
        req1_valid = 1'b1;
        req1_addr  = 5'd0;
        req1_data  = 64'hFFFF;
        #1;
        chk("x0_ready1", req1_ready, 1);
        chk("x0_ready0", req0_ready, 0);
        tick();
        req1_valid = 1'b0;
        chk("x0_write", write, 0);
        chk("x0_conflict", conflict_cnt, 0);

        // Contention on the same address: req0 then req1, last write wins
        req0_valid = 1'b1;
        req0_addr  = 5'd3;
        req0_data  = 64'hA;
        req1_valid = 1'b1;
        req1_addr  = 5'd3;
        req1_data  = 64'hB;
        #1;
        chk("both_ready0", req0_ready, 1);
        chk("both_ready1", req1_ready, 0);
        tick();
        req0_valid = 1'b0;
        chk("both_w1_addr", regwriteaddress, 3);
        chk("both_w1_data", datain, 64'hA);
        #1;
        chk("both_next_ready1", req1_ready, 1);
        tick();
        req1_valid = 1'b0;
        chk("both_w2_write", write, 1);
        chk("both_w2_data", datain, 64'hB);
        chk("both_conflict", conflict_cnt, 1);
        tick();
        chk("both_bank3", bank[3], 64'hB);

        // Reset from RUN, then reset again when clear reaches address 10
        reset = 1'b1;
        tick();
        chk("rrun_write", write, 0);
        chk("rrun_conflict", conflict_cnt, 0);
        chk("rrun_busy", busy_clear, 1);
        reset = 1'b0;
        for (int i = 0; i <= 10; i++) begin
            tick();
            chk("pclr_addr", regwriteaddress, i);
        end
        reset = 1'b1;
        tick();
        chk("mid_write", write, 0);
        reset = 1'b0;
        for (int i = 0; i < NREGS; i++) begin
            tick();
            chk("reclr_write", write, 1);
            chk("reclr_addr", regwriteaddress, i);
        end
        tick();
        chk("reclr_done", busy_clear, 0);

        // Sustained contention: alternating grants and counter saturation
        req0_valid = 1'b1;
        req0_addr  = 5'd9;
        req0_data  = 64'h100;
        req1_valid = 1'b1;
        req1_addr  = 5'd9;
        req1_data  = 64'h200;
        exp0 = 1'b1;
        for (int k = 1; k <= 70000; k++) begin
            #1;
            chk("rr_ready0", req0_ready, exp0);
            chk("rr_ready1", req1_ready, !exp0);
            tick();
            chk("rr_data", datain, exp0 ? 64'h100 : 64'h200);
            exp0 = !exp0;
            if (k == 65534) chk("sat_pre", conflict_cnt, 16'hFFFE);
            if (k == 65535) chk("sat_hit", conflict_cnt, 16'hFFFF);
        end
        chk("sat_hold", conflict_cnt, 16'hFFFF);
        req0_valid = 1'b0;
        req1_valid = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
